regfile_sb: RTL

Parametrised multi-port integer register file for the pipelined core, successor to the single-write/two-read file. Adds N read and M write ports, same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a handshaked serial dump engine that replaces the simulation-only halt dump. It sits between decode (read, issue) and writeback (write), and feeds the test harness through the dump port.

---
 rtl/regfile_sb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass, a per-register
// busy scoreboard for hazard detection, and a handshaked serial dump engine.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NRD*AW-1:0]    rs_num,
    output logic [NRD*XLEN-1:0]  rs_data,
    output logic [NRD-1:0]       rs_busy,
    input  logic [NWR-1:0]       rd_we,
    input  logic [NWR*AW-1:0]    rd_num,
    input  logic [NWR*XLEN-1:0]  rd_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_num,
    input  logic                 dump_req,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [AW-1:0]        dump_idx,
    output logic [XLEN-1:0]      dump_data,
    output logic                 dump_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic [AW-1:0]    rd_idx_s [NRD];
    logic [XLEN-1:0]  rd_val_s [NRD];

    // Which registers receive an enabled write this cycle (r0 never counts).
    always_comb begin
        wr_hit_s = '0;
        for (int w = 0; w < NWR; w++) begin
            for (int i = 1; i < NREGS; i++) begin
                wr_hit_s[i] = wr_hit_s[i] | (rd_we[w] & (rd_num[w*AW +: AW] == AW'(i)));
            end
        end
    end

    // Next register contents: ascending port scan so the highest port wins.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
            for (int w = 0; w < NWR; w++) begin
                mem_d[i] = (rd_we[w] && (rd_num[w*AW +: AW] == AW'(i))) ?
                           rd_data[w*XLEN +: XLEN] : mem_d[i];
            end
        end
        mem_d[0] = '0;
    end

    // Scoreboard: a new issue outranks a same-cycle writeback clear.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = (busy_q[i] & ~wr_hit_s[i]) |
                        (iss_valid & (iss_num == AW'(i)));
        end
        busy_d[0] = 1'b0;
    end

    // Read ports: stored value, optionally overridden by same-cycle write data.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_idx_s[p] = rs_num[p*AW +: AW];
            rd_val_s[p] = mem_q[rd_idx_s[p]];
            for (int w = 0; w < NWR; w++) begin
                rd_val_s[p] = ((BYPASS != 0) && rd_we[w] && (rd_idx_s[p] != '0) &&
                               (rd_num[w*AW +: AW] == rd_idx_s[p])) ?
                              rd_data[w*XLEN +: XLEN] : rd_val_s[p];
            end
            rs_data[p*XLEN +: XLEN] = rd_val_s[p];
            rs_busy[p] = busy_q[rd_idx_s[p]] &
                         ~((BYPASS != 0) & wr_hit_s[rd_idx_s[p]]);
        end
    end

    // Dump sequencer; idx wraps to 0 after the last beat since NREGS is a power of two.
    always_comb begin
        state_d = ST_IDLE;
        idx_d   = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = dump_req ? ST_DUMP : ST_IDLE;
                idx_d   = '0;
            end
            ST_DUMP: begin
                if (dump_ready) begin
                    state_d = (idx_q == AW'(NREGS - 1)) ? ST_DONE : ST_DUMP;
                    idx_d   = idx_q + 1'b1;
                end else begin
                    state_d = ST_DUMP;
                    idx_d   = idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump outputs come straight from state; dump_data reflects stored (post-write) values.
    assign dump_valid = (state_q == ST_DUMP);
    assign dump_done  = (state_q == ST_DONE);
    assign dump_idx   = idx_q;
    assign dump_data  = mem_q[idx_q];

endmodule
